// File: rtl/vgc_pkg.sv
// Shared constants and helpers for the VGC timing block: register offsets,
// VGCINT field layout and counter-encoding helpers.
package vgc_pkg;

  // Soft-switch offsets (low byte of $C0xx)
  localparam logic [7:0] VGC_RDVBL  = 8'h19;
  localparam logic [7:0] VGC_INT    = 8'h23;
  localparam logic [7:0] VGC_VCNT   = 8'h2E;
  localparam logic [7:0] VGC_HCNT   = 8'h2F;
  localparam logic [7:0] VGC_CLRINT = 8'h32;

  // VGCINT bit positions
  localparam int INT_EN_LINE   = 1;
  localparam int INT_EN_SEC    = 2;
  localparam int INT_PEND_LINE = 5;
  localparam int INT_PEND_SEC  = 6;
  localparam int INT_ANY       = 7;

  // Offset applied to the line count so that $C02E wraps like the real VGC
  localparam logic [8:0] VC_OFFSET = 9'h0FA;

  // VGCINT read image
  typedef struct packed {
    logic       any;
    logic       pend_sec;
    logic       pend_line;
    logic [1:0] rsvd_hi;
    logic       en_sec;
    logic       en_line;
    logic       rsvd_lo;
  } vgcint_t;

  // Single bit of a data byte, selected by position
  function automatic logic bit_at(input logic [7:0] d, input int pos);
    return (d & (8'd1 << pos)) != 8'd0;
  endfunction

  // Horizontal count as seen in $C02F: 0, then $40..$7F
  function automatic logic [6:0] hcnt_enc(input logic [9:0] h);
    return (h == 10'd0) ? 7'd0 : 7'(10'h040 + h - 10'd1);
  endfunction

endpackage

// File: rtl/vgc_timing_if.sv
// Register strobe port between the I/O decoder (master) and the VGC (slave).
interface vgc_timing_if;
  logic [7:0] addr;
  logic       rw;
  logic       strobe;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output addr, rw, strobe, din, input dout);
  modport slave  (input addr, rw, strobe, din, output dout);
endinterface

// File: rtl/vgc_raster_cnt.sv
// Raster counters: H/V position, registered VBlank and the frame counter
// that produces the one-second tick.
module vgc_raster_cnt #(
  parameter int H_TOTAL    = 65,
  parameter int V_TOTAL    = 262,
  parameter int V_VBL      = 192,
  parameter int FRAMES_SEC = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cen,
  output logic [9:0] h,
  output logic [8:0] v,
  output logic [8:0] v_nxt,
  output logic       vblank,
  output logic       line_start,
  output logic       frame_end,
  output logic       sec_tick
);

  logic [9:0] h_nxt;
  logic [5:0] fcnt;
  logic       h_last, v_last, fcnt_last;

  assign h_last     = (h == 10'(H_TOTAL - 1));
  assign v_last     = (v == 9'(V_TOTAL - 1));
  assign fcnt_last  = (fcnt == 6'(FRAMES_SEC - 1));
  assign line_start = cen & h_last;
  assign frame_end  = line_start & v_last;
  assign sec_tick   = frame_end & fcnt_last;

  // Next raster position; v_nxt is exported so SCB lookups see the new line
  always_comb begin
    h_nxt = h;
    v_nxt = v;
    if (cen) begin
      if (h_last) begin
        h_nxt = 10'd0;
        v_nxt = v_last ? 9'd0 : v + 9'd1;
      end else begin
        h_nxt = h + 10'd1;
      end
    end
  end

  // Position and VBlank register, all updated on the same cen edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h      <= '0;
      v      <= '0;
      vblank <= 1'b0;
    end else if (cen) begin
      h      <= h_nxt;
      v      <= v_nxt;
      vblank <= (v_nxt >= 9'(V_VBL));
    end
  end

  // Frame counter, wraps once per second of frames
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       fcnt <= '0;
    else if (frame_end) fcnt <= fcnt_last ? 6'd0 : fcnt + 6'd1;
  end

endmodule

// File: rtl/vgc_timing.sv
// VGC timing top: raster counters, VGCINT enable/pending state, registered
// register-read port and the CPU IRQ line.
module vgc_timing
  import vgc_pkg::*;
#(
  parameter int H_TOTAL    = 65,
  parameter int V_TOTAL    = 262,
  parameter int V_VBL      = 192,
  parameter int V_SHR      = 200,
  parameter int FRAMES_SEC = 60
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cen,
  vgc_timing_if.slave  bus,
  input  logic         scb_irq,
  output logic [7:0]   scb_line,
  output logic [9:0]   H,
  output logic [8:0]   V,
  output logic         VBlank,
  output logic         irq_n
);

  logic [8:0] v_nxt, vc;
  logic [6:0] hc;
  logic       line_start, frame_end, sec_tick;
  logic       en_sec, en_line, pend_sec, pend_line, any_irq;
  logic       wr, rd, wr_int, wr_clr, clr_sec, clr_line, set_line, set_sec;
  logic       rd_hit;
  logic [7:0] rd_data, dout_q;
  vgcint_t    int_rd;

  vgc_raster_cnt #(
    .H_TOTAL    (H_TOTAL),
    .V_TOTAL    (V_TOTAL),
    .V_VBL      (V_VBL),
    .FRAMES_SEC (FRAMES_SEC)
  ) u_raster (
    .clk        (clk),
    .reset_n    (reset_n),
    .cen        (cen),
    .h          (H),
    .v          (V),
    .v_nxt      (v_nxt),
    .vblank     (VBlank),
    .line_start (line_start),
    .frame_end  (frame_end),
    .sec_tick   (sec_tick)
  );

  // The SCB is looked up for the line being entered, not the current one
  assign scb_line = v_nxt[7:0];

  assign wr       = bus.strobe & ~bus.rw;
  assign rd       = bus.strobe &  bus.rw;
  assign wr_int   = wr & (bus.addr == VGC_INT);
  assign wr_clr   = wr & (bus.addr == VGC_CLRINT);
  assign clr_sec  = wr_clr & ~bit_at(bus.din, INT_PEND_SEC);
  assign clr_line = wr_clr & ~bit_at(bus.din, INT_PEND_LINE);
  assign set_line = line_start & (v_nxt < 9'(V_SHR)) & scb_irq;
  assign set_sec  = frame_end & sec_tick;
  assign any_irq  = (pend_sec & en_sec) | (pend_line & en_line);

  // Enable bits follow $23 writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_sec  <= 1'b0;
      en_line <= 1'b0;
    end else if (wr_int) begin
      en_sec  <= bit_at(bus.din, INT_EN_SEC);
      en_line <= bit_at(bus.din, INT_EN_LINE);
    end
  end

  // Pending bits: a set in the same cycle as a $32 clear wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_sec  <= 1'b0;
      pend_line <= 1'b0;
    end else begin
      pend_sec  <= set_sec  | (pend_sec  & ~clr_sec);
      pend_line <= set_line | (pend_line & ~clr_line);
    end
  end

  // IRQ line lags the pending/enable state by one register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_n <= 1'b1;
    else          irq_n <= ~any_irq;
  end

  assign vc = V + VC_OFFSET;
  assign hc = hcnt_enc(H);

  always_comb begin
    int_rd           = '0;
    int_rd.any       = any_irq;
    int_rd.pend_sec  = pend_sec;
    int_rd.pend_line = pend_line;
    int_rd.en_sec    = en_sec;
    int_rd.en_line   = en_line;
  end

  // Read mux over the pre-edge state; unknown offsets leave dout alone
  always_comb begin
    rd_hit  = 1'b1;
    rd_data = 8'h00;
    case (bus.addr)
      VGC_RDVBL: rd_data = {~VBlank, 7'b0};
      VGC_INT:   rd_data = int_rd;
      VGC_VCNT:  rd_data = vc[8:1];
      VGC_HCNT:  rd_data = {vc[0], hc};
      default:   rd_hit  = 1'b0;
    endcase
  end

  // Registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          dout_q <= 8'h00;
    else if (rd && rd_hit) dout_q <= rd_data;
  end

  assign bus.dout = dout_q;

endmodule

// File: tb/tb_vgc_timing.sv
// Directed + randomized bench for vgc_timing. The reference model tracks the
// total number of cen pulses since reset and derives position, VBlank,
// line starts and one-second ticks arithmetically from it.
module tb_vgc_timing;

  localparam int HT = 65;
  localparam int VT = 262;
  localparam int FS = 2;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cen;
  logic       scb_irq;
  logic [7:0] scb_line;
  logic [9:0] H;
  logic [8:0] V;
  logic       VBlank;
  logic       irq_n;

  vgc_timing_if bus ();

  vgc_timing #(.FRAMES_SEC(FS)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cen      (cen),
    .bus      (bus),
    .scb_irq  (scb_irq),
    .scb_line (scb_line),
    .H        (H),
    .V        (V),
    .VBlank   (VBlank),
    .irq_n    (irq_n)
  );

  always #5 clk = ~clk;

  // Upstream SCB table: bit 6 of each line's SCB
  logic [255:0] scb_tab;
  assign scb_irq = scb_tab[scb_line];

  int         nvec = 0, nerr = 0, vbl_cnt = 0;
  int         t;
  bit         m_es, m_el, m_ps, m_pl, iexp;
  logic [7:0] dexp;
  logic [7:0] addrs [7] = '{8'h19, 8'h23, 8'h2E, 8'h2F, 8'h32, 8'h00, 8'hC0};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, check after the edge
  task automatic step(input bit c, input bit s, input bit r,
                      input logic [7:0] a, input logic [7:0] d);
    int h, v, nt, nv, vc, hc;
    bit b7, set_l, set_s;
    cen = c; bus.strobe = s; bus.rw = r; bus.addr = a; bus.din = d;
    h  = t % HT;
    v  = (t / HT) % VT;
    b7 = (m_ps && m_es) || (m_pl && m_el);
    vc = (v + 250) % 512;
    hc = (h == 0) ? 0 : 63 + h;
    if (s && r) begin
      case (a)
        8'h19: dexp = (v >= 192) ? 8'h00 : 8'h80;
        8'h23: dexp = {b7, m_ps, m_pl, 2'b00, m_es, m_el, 1'b0};
        8'h2E: dexp = 8'(vc / 2);
        8'h2F: dexp = 8'((vc % 2) * 128 + hc);
        default: ;
      endcase
    end
    set_l = 0; set_s = 0;
    if (c) begin
      nt = t + 1;
      if (nt % HT == 0) begin
        nv = (nt / HT) % VT;
        set_l = (nv < 200) && scb_tab[nv];
      end
      set_s = (nt % (FRAME * FS)) == 0;
      t = nt;
    end
    if (s && !r && a == 8'h23) begin m_es = d[2]; m_el = d[1]; end
    if (s && !r && a == 8'h32) begin
      if (!d[6]) m_ps = 0;
      if (!d[5]) m_pl = 0;
    end
    m_ps = m_ps | set_s;
    m_pl = m_pl | set_l;
    iexp = !b7;
    @(posedge clk);
    #1;
    v = (t / HT) % VT;
    chk("H", 16'(H), 16'(t % HT));
    chk("V", 16'(V), 16'(v));
    chk("VBlank", 16'(VBlank), 16'(v >= 192));
    chk("irq_n", 16'(irq_n), 16'(iexp));
    chk("dout", 16'(bus.dout), 16'(dexp));
    if (c && VBlank) vbl_cnt++;
  endtask

  task automatic run_to(input int target);
    while (t < target) step(1, 0, 1, 8'h00, 8'h00);
  endtask

  task automatic rd(input logic [7:0] a);
    step(0, 1, 1, a, 8'h00);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    step(0, 1, 0, a, d);
  endtask

  task automatic model_reset();
    t = 0; m_es = 0; m_el = 0; m_ps = 0; m_pl = 0;
    dexp = 8'h00; iexp = 1; vbl_cnt = 0;
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_H"}, 16'(H), 16'd0);
    chk({pfx, "_V"}, 16'(V), 16'd0);
    chk({pfx, "_VBlank"}, 16'(VBlank), 16'd0);
    chk({pfx, "_irq_n"}, 16'(irq_n), 16'd1);
    chk({pfx, "_dout"}, 16'(bus.dout), 16'd0);
  endtask

  initial begin
    reset_n = 0; cen = 0; bus.strobe = 0; bus.rw = 1;
    bus.addr = 8'h00; bus.din = 8'h00; scb_tab = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    reset_n = 1;

    // Counter encoding at the top of the frame
    rd(8'h2E); chk("vcnt_v0h0", 16'(bus.dout), 16'h7D);
    rd(8'h2F); chk("hcnt_v0h0", 16'(bus.dout), 16'h00);
    step(1, 0, 1, 8'h00, 8'h00);
    rd(8'h2E); chk("vcnt_v0h1", 16'(bus.dout), 16'h7D);
    rd(8'h2F); chk("hcnt_v0h1", 16'(bus.dout), 16'h40);

    // Scanline IRQ on line 5 only
    scb_tab = '0; scb_tab[5] = 1'b1;
    wr(8'h23, 8'h02);
    run_to(5 * HT - 1);
    step(1, 0, 1, 8'h00, 8'h00);
    rd(8'h23); chk("line_int_rd", 16'(bus.dout), 16'hA2);
    chk("line_irq_low", 16'(irq_n), 16'd0);
    wr(8'h32, 8'hDF);
    rd(8'h23); chk("line_clr_rd", 16'(bus.dout), 16'h02);
    chk("line_irq_high", 16'(irq_n), 16'd1);

    // Clear colliding with a line-7 set: set wins
    scb_tab = '0; scb_tab[7] = 1'b1;
    run_to(7 * HT - 1);
    step(1, 1, 0, 8'h32, 8'h00);
    rd(8'h23); chk("collision_rd", 16'(bus.dout), 16'hA2);
    wr(8'h32, 8'h00);

    // Randomized traffic with random cen gaps and SCB contents
    for (int i = 0; i < 1500; i++) begin
      if (i % 200 == 0)
        for (int k = 0; k < 8; k++) scb_tab[k*32 +: 32] = $urandom;
      step($urandom_range(3, 0) != 0, $urandom_range(1, 0) != 0,
           $urandom_range(1, 0) != 0, addrs[$urandom_range(6, 0)], 8'($urandom));
    end
    scb_tab = '0;
    wr(8'h23, 8'h00);
    wr(8'h32, 8'h00);

    // Rest of frame 1: VBlank read, end-of-frame encoding, wrap
    run_to(100 * HT + 10);
    rd(8'h19); chk("rdvbl_line100", 16'(bus.dout), 16'h80);
    run_to(261 * HT + 64);
    rd(8'h2E); chk("vcnt_v261h64", 16'(bus.dout), 16'hFF);
    rd(8'h2F); chk("hcnt_v261h64", 16'(bus.dout), 16'hFF);
    step(1, 0, 1, 8'h00, 8'h00);
    chk("frame_wrap_V", 16'(V), 16'd0);
    chk("vblank_pulses", 16'(vbl_cnt), 16'(70 * HT));

    // One-second tick with the enable off, then enabled
    run_to(FS * FRAME - 1);
    step(1, 0, 1, 8'h00, 8'h00);
    rd(8'h23); chk("sec_noen_rd", 16'(bus.dout), 16'h40);
    step(0, 0, 1, 8'h00, 8'h00);
    chk("sec_noen_irq", 16'(irq_n), 16'd1);
    wr(8'h23, 8'h04);
    rd(8'h23); chk("sec_en_rd", 16'(bus.dout), 16'hC4);
    chk("sec_en_irq", 16'(irq_n), 16'd0);

    // Asynchronous reset at line 150 with the IRQ asserted
    run_to(FS * FRAME + 150 * HT);
    chk("pre_reset_V", 16'(V), 16'd150);
    chk("pre_reset_irq", 16'(irq_n), 16'd0);
    reset_n = 0;
    #2;
    chk_reset_state("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1;
    repeat (5) step(1, 0, 1, 8'h00, 8'h00);
    chk("resume_H", 16'(H), 16'd5);
    chk("resume_V", 16'(V), 16'd0);
    rd(8'h23); chk("resume_int_rd", 16'(bus.dout), 16'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
